cache_control_p: RTL

- Control FSM that sequences the two-way pipelined cache datapath (cache_datapath_p).
- Stage 1 (cycle N): the CPU request indexes the ways. Stage 2 (cycle N+1): registered compare results return and this block decides hit, writeback or allocate.
- Drives all datapath select/load strobes, the CPU response/stall, and the cacheline-adaptor read/write handshake.
- Sits between the CPU memory port, cache_datapath_p and the cacheline adaptor.

---
 rtl/cache_control_p_pkg.sv | 14 +
 rtl/cache_control_p_perf_cnt.sv | 19 +
 rtl/cache_control_p.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cache_control_p_pkg.sv
// rtl/cache_control_p_pkg.sv - state encoding and way constants shared by the cache controller
package cache_ctrl_types;

    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        REPLAY    = 2'd3
    } cache_state_t;

    localparam logic WAY0 = 1'b0;
    localparam logic WAY1 = 1'b1;

endpackage

// File: rtl/cache_control_p_perf_cnt.sv
// rtl/cache_control_p_perf_cnt.sv - single saturating event counter used for cache statistics
module cache_perf_cnt #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [PERF_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {PERF_W{1'b1}})) begin
            count <= count + PERF_W'(1);
        end
    end

endmodule

// File: rtl/cache_control_p.sv
// rtl/cache_control_p.sv - two-way pipelined cache control FSM; CACHE_PERF_CNT_EN adds hit/miss/writeback counters
module cache_control_p
    import cache_ctrl_types::*;
#(
    parameter int PERF_W = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_read,
    input  logic mem_write,
    output logic mem_resp,
    output logic stall,
    output logic pmem_read,
    output logic pmem_write,
    input  logic pmem_resp,
    input  logic cache_hit,
    input  logic hit1,
    input  logic dirty_o,
    input  logic lru_out,
    output logic source_sel,
    output logic way_sel,
    output logic tag_sel,
    output logic addrmux_sel,
    output logic load_cache,
    output logic load_lru,
    output logic load_dirty,
    output logic dirty_sel
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] hit_count,
    output logic [PERF_W-1:0] miss_count,
    output logic [PERF_W-1:0] wb_count
`endif
);

    cache_state_t state, state_n;
    logic         req_v, req_wr;
    logic         victim, victim_n;

    // Stage-2 request flags follow the CPU only while it is free to move on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= COMPARE;
            req_v  <= 1'b0;
            req_wr <= 1'b0;
            victim <= WAY0;
        end else begin
            state  <= state_n;
            victim <= victim_n;
            if (!stall) begin
                req_v  <= mem_read | mem_write;
                req_wr <= mem_write;
            end
        end
    end

    always_comb begin
        state_n     = state;
        victim_n    = victim;
        mem_resp    = 1'b0;
        stall       = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        source_sel  = 1'b0;
        way_sel     = WAY0;
        tag_sel     = 1'b0;
        addrmux_sel = 1'b0;
        load_cache  = 1'b0;
        load_lru    = 1'b0;
        load_dirty  = 1'b0;
        dirty_sel   = 1'b0;
        case (state)
            COMPARE: begin
                if (req_v) begin
                    if (cache_hit) begin
                        mem_resp = 1'b1;
                        way_sel  = hit1 ? WAY1 : WAY0;
                        load_lru = 1'b1;
                        if (req_wr) begin
                            addrmux_sel = 1'b1;
                            load_cache  = 1'b1;
                            load_dirty  = 1'b1;
                            dirty_sel   = 1'b1;
                        end
                    end else begin
                        stall       = 1'b1;
                        addrmux_sel = 1'b1;
                        victim_n    = lru_out;
                        state_n     = dirty_o ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write  = 1'b1;
                way_sel     = victim;
                addrmux_sel = 1'b1;
                stall       = 1'b1;
                if (pmem_resp) begin
                    state_n = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read   = 1'b1;
                tag_sel     = 1'b1;
                way_sel     = victim;
                addrmux_sel = 1'b1;
                stall       = 1'b1;
                if (pmem_resp) begin
                    load_cache = 1'b1;
                    source_sel = 1'b1;
                    load_dirty = 1'b1;
                    state_n    = REPLAY;
                end
            end
            REPLAY: begin
                // Let the pipeline registers re-read the freshly filled line.
                addrmux_sel = 1'b1;
                stall       = 1'b1;
                state_n     = COMPARE;
            end
            default: begin
                state_n = COMPARE;
            end
        endcase
    end

    assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write))
        else $fatal(1, "cache_control_p: mem_read and mem_write asserted together");

`ifdef CACHE_PERF_CNT_EN
    logic hit_evt, miss_evt, wb_evt;

    assign hit_evt  = (state == COMPARE) && req_v && cache_hit;
    assign miss_evt = (state == COMPARE) && req_v && !cache_hit;
    assign wb_evt   = (state == WRITEBACK) && pmem_resp;

    cache_perf_cnt #(.PERF_W(PERF_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_evt),
        .count (hit_count)
    );

    cache_perf_cnt #(.PERF_W(PERF_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_evt),
        .count (miss_count)
    );

    cache_perf_cnt #(.PERF_W(PERF_W)) u_wb_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (wb_evt),
        .count (wb_count)
    );
`else
    // PERF_W only sizes the counters; keep the override meaningful in both builds.
    if (PERF_W < 1) begin : g_bad_perf_w
    end
`endif

endmodule
